// File: rtl/uart_tx_if.sv
// uart_tx_if: parallel-word request and serial line/busy bundle for uart_tx
interface uart_tx_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      Data_Valid;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic                      TX_OUT;
    logic                      Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        output TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1/8E1/8O1 serialiser, each bit held for Prescale oversampling clocks
module uart_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input logic     uart_tx_clk,
    input logic     uart_tx_rst,
    uart_tx_if.slave bus
);
    localparam int BW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                    state;
    logic [PRESCALE_WIDTH-1:0] cnt;
    logic [PRESCALE_WIDTH-1:0] p;
    logic [BW-1:0]             idx;
    logic [DATA_WIDTH-1:0]     data;
    logic                      par_en;
    logic                      par_bit;
    logic                      tx;
    logic                      busy;
    logic                      last;
    logic                      accept;

    assign last   = cnt == p - PRESCALE_WIDTH'(1);
    // the final STOP cycle also accepts, giving zero-gap back-to-back frames
    assign accept = bus.Data_Valid && (state == IDLE || (state == STOP && last));
    assign bus.TX_OUT = tx;
    assign bus.Busy   = busy;

    always_ff @(posedge uart_tx_clk or negedge uart_tx_rst) begin
        if (!uart_tx_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            p       <= '0;
            idx     <= '0;
            data    <= '0;
            par_en  <= 1'b0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else if (accept) begin
            state   <= START;
            cnt     <= '0;
            idx     <= '0;
            data    <= bus.P_DATA;
            par_en  <= bus.PAR_EN;
            par_bit <= bus.PAR_TYP ? ~^bus.P_DATA : ^bus.P_DATA;
            p       <= bus.Prescale < PRESCALE_WIDTH'(2) ? PRESCALE_WIDTH'(8) : bus.Prescale;
            tx      <= 1'b0;
            busy    <= 1'b1;
        end else if (state != IDLE) begin
            cnt <= last ? '0 : cnt + PRESCALE_WIDTH'(1);
            if (last) begin
                case (state)
                    START: begin
                        state <= DATA;
                        tx    <= data[0];
                    end
                    DATA: begin
                        if (idx == BW'(DATA_WIDTH - 1)) begin
                            state <= par_en ? PARITY : STOP;
                            tx    <= par_en ? par_bit : 1'b1;
                        end else begin
                            idx <= idx + BW'(1);
                            tx  <= data[idx + BW'(1)];
                        end
                    end
                    PARITY: begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frame checks of uart_tx, busy/line compared every cycle
module tb_uart_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    uart_tx_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) bus ();

    uart_tx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .uart_tx_clk(clk),
        .uart_tx_rst(rst_n),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int cyc, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d busy/tx observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // bits[k] is the k-th transmitted bit; checks frame cycles [from, to)
    task automatic frame(input string tag, input logic [10:0] bits, input int p, input int from, input int to);
        for (int c = from; c < to; c++) begin
            chk(tag, c, {bus.Busy, bus.TX_OUT}, {1'b1, bits[c / p]});
            @(negedge clk);
        end
    endtask

    task automatic start(input logic [7:0] d, input logic pen, input logic ptyp, input logic [5:0] ps);
        bus.P_DATA     = d;
        bus.PAR_EN     = pen;
        bus.PAR_TYP    = ptyp;
        bus.Prescale   = ps;
        bus.Data_Valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input string tag);
        chk(tag, -1, {bus.Busy, bus.TX_OUT}, 2'b01);
    endtask

    initial begin
        bus.P_DATA     = 8'h00;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.Prescale   = 6'd8;
        #23;
        idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle("post_reset");

        start(8'hA5, 1'b0, 1'b0, 6'd8);
        bus.Data_Valid = 1'b0;
        bus.P_DATA     = 8'h00;
        bus.PAR_EN     = 1'b1;
        bus.Prescale   = 6'd16;
        frame("a5_p8", {1'b0, 1'b1, 8'hA5, 1'b0}, 8, 0, 80);
        idle("a5_end");

        start(8'h07, 1'b1, 1'b0, 6'd16);
        bus.Data_Valid = 1'b0;
        bus.PAR_TYP    = 1'b1;
        frame("07_even", {1'b1, 1'b1, 8'h07, 1'b0}, 16, 0, 176);
        idle("07_even_end");

        start(8'h07, 1'b1, 1'b1, 6'd16);
        bus.Data_Valid = 1'b0;
        bus.PAR_TYP    = 1'b0;
        frame("07_odd", {1'b1, 1'b0, 8'h07, 1'b0}, 16, 0, 176);
        idle("07_odd_end");

        start(8'h00, 1'b1, 1'b0, 6'd32);
        bus.Data_Valid = 1'b0;
        frame("00_p32", {1'b1, 1'b0, 8'h00, 1'b0}, 32, 0, 352);
        idle("00_p32_end");

        start(8'h81, 1'b0, 1'b0, 6'd0);
        bus.Data_Valid = 1'b0;
        frame("ps0_as_8", {1'b0, 1'b1, 8'h81, 1'b0}, 8, 0, 80);
        idle("ps0_end");

        start(8'h3C, 1'b0, 1'b0, 6'd8);
        bus.P_DATA = 8'hC3;
        frame("b2b_first", {1'b0, 1'b1, 8'h3C, 1'b0}, 8, 0, 80);
        bus.Data_Valid = 1'b0;
        frame("b2b_second", {1'b0, 1'b1, 8'hC3, 1'b0}, 8, 0, 80);
        idle("b2b_end");

        start(8'h00, 1'b0, 1'b0, 6'd8);
        bus.Data_Valid = 1'b0;
        frame("ignore_pre", {1'b0, 1'b1, 8'h00, 1'b0}, 8, 0, 20);
        bus.P_DATA     = 8'hFF;
        bus.Data_Valid = 1'b1;
        frame("ignore_pulse", {1'b0, 1'b1, 8'h00, 1'b0}, 8, 20, 21);
        bus.Data_Valid = 1'b0;
        frame("ignore_post", {1'b0, 1'b1, 8'h00, 1'b0}, 8, 21, 80);
        idle("ignore_end");

        start(8'hF0, 1'b0, 1'b0, 6'd8);
        bus.Data_Valid = 1'b0;
        frame("pre_abort", {1'b0, 1'b1, 8'hF0, 1'b0}, 8, 0, 30);
        rst_n = 1'b0;
        #1;
        idle("abort_async");
        @(negedge clk);
        @(negedge clk);
        idle("abort_held");
        rst_n = 1'b1;
        start(8'h55, 1'b0, 1'b0, 6'd8);
        bus.Data_Valid = 1'b0;
        frame("55_after_rst", {1'b0, 1'b1, 8'h55, 1'b0}, 8, 0, 80);
        idle("55_end");
        @(negedge clk);
        idle("idle_hold");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that pairs with the receiver path. It accepts one 8-bit parallel word per handshake and serialises it onto TX_OUT as an 8N1/8E1/8O1 frame. It runs on the same oversampling clock as the receiver, holding each bit for Prescale clock cycles, so both ends share one clock and one Prescale setting.

## Interface
Parameters:
- DATA_WIDTH, 8, payload bits per frame (only 8 is verified)
- PRESCALE_WIDTH, 6, width of Prescale (holds 8, 16, 32)

Ports:
- uart_tx_clk  in  1  oversampling clock; all state changes on rising edge
- uart_tx_rst  in  1  asynchronous, active-low reset
- P_DATA  in  8  parallel word to send
- Data_Valid  in  1  request; accepted per handshake rules below
- PAR_EN  in  1  1 = insert parity bit after data
- PAR_TYP  in  1  0 = even parity, 1 = odd parity
- Prescale  in  6  clock cycles per bit; legal 8/16/32
- TX_OUT  out  1  serial line, idles high
- Busy  out  1  high from frame accept until the frame ends

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Accept: an edge where Data_Valid=1 and the FSM is in IDLE, or in the last cycle of STOP. At that edge, latch P_DATA, PAR_EN, PAR_TYP and Prescale, compute the parity bit, and go to START. Inputs may change afterwards without affecting the frame.
- Data_Valid=1 at any other edge is ignored. No queueing and no error flag.
- Parity bit = ^data when PAR_TYP=0; ~^data when PAR_TYP=1.
- Bit order on TX_OUT:
  - start bit 0
  - data[0]..data[7], LSB first
  - parity bit, only if PAR_EN
  - stop bit 1
- Each bit lasts exactly P cycles, where P is the latched Prescale. Prescale 0 or 1 is treated as 8. Any other value 2..63 is used literally.
- Internal counters:
  - edge counter 0..P-1; wraps at P-1 and advances the bit
  - bit index 0..7, used in DATA
- Transitions:
  - IDLE→START on accept
  - START→DATA after P cycles
  - DATA→PARITY (PAR_EN=1) or DATA→STOP (PAR_EN=0) after the 8th bit
  - PARITY→STOP after P cycles
  - STOP→IDLE after P cycles, or STOP→START if accept occurs on that edge (back-to-back)
- TX_OUT and Busy are registered. There is no combinational path from any input to any output.

## Timing
- Reset (async assert, any state): TX_OUT=1, Busy=0, FSM=IDLE, counters=0, latched registers=0. Takes effect immediately, mid-frame included; the frame is abandoned.
- Reset deassertion: the first accept can occur on the first following rising edge.
- Accept edge E0: from E0 onward, TX_OUT=0 and Busy=1.
- Bit k (k=0 is the start bit) occupies cycles [E0+k·P, E0+(k+1)·P).
- Frame length N·P cycles, with N=10 (no parity) or 11 (parity).
- At edge E0+N·P:
  - without a new accept: TX_OUT=1, Busy=0
  - with Data_Valid=1 on that edge: new frame accepted, TX_OUT=0 for the new start bit, Busy stays 1. Zero idle cycles between frames.
- While IDLE: TX_OUT=1, Busy=0.
- Changes to PAR_EN, PAR_TYP or Prescale mid-frame have no effect until the next accept.

## Test plan
- Reset → TX_OUT=1, Busy=0. Assert reset mid-DATA → TX_OUT=1, Busy=0 immediately. After release, a new 0x55 frame transmits cleanly.
- P_DATA=0xA5, PAR_EN=0, Prescale=8 → TX_OUT sequence 0,1,0,1,0,0,1,0,1,1, 8 cycles per bit. Busy high exactly 80 cycles.
- P_DATA=0x07, PAR_EN=1, PAR_TYP=0, Prescale=16 → parity bit 1, frame 176 cycles. Repeat with PAR_TYP=1 → parity bit 0.
- Prescale=32 and P_DATA=0x00 with even parity → 11 bits of 32 cycles. Parity 0, stop bit 1, Busy high 352 cycles.
- Hold Data_Valid=1 continuously with P_DATA=0x3C, then 0xC3 (PAR_EN=0, Prescale=8) → first frame accepted. Changes during the frame are ignored. The second frame's start bit begins at cycle 80, with no idle gap and Busy never low.
- Pulse Data_Valid with 0xFF at cycle 20 of a 0x00 frame (PAR_EN=0, Prescale=8) → no effect on TX_OUT, 0x00 frame completes, Busy falls at cycle 80.
